pio_decode_stage: RTL and testbench
===================================

PIO_DECODE_STAGE -- requirements
Module: pio_decode_stage

Interface
REQ-001 SHALL have parameter MAX_SIDESET, default 5: largest honoured side-set width; sideset_bits above it clamp to MAX_SIDESET.
REQ-002 SHALL have parameter DCNT_W, default 5: delay counter width, minimum 5.
REQ-003 SHALL have port pclk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port instr, input, 16: PIO instruction word.
REQ-006 SHALL have port instr_valid, input, 1: instr present.
REQ-007 SHALL have port instr_ready, output, 1: stage accepts instr this cycle.
REQ-008 SHALL have port sideset_bits, input, 3: configured side-set width, sampled at accept.
REQ-009 SHALL have port flush, input, 1: abort current instruction (jump/restart).
REQ-010 SHALL have ports op (3), op1 (3), op2 (5), delay (5), side_set (5), all outputs: registered decoded fields.
REQ-011 SHALL have port side_set_en, output, 1: side_set is to be applied.
REQ-012 SHALL have port out_valid, output, 1: decoded fields valid.
REQ-013 SHALL have port out_ready, input, 1: consumer takes decoded fields.
REQ-014 SHALL have port busy, output, 1: delay countdown in progress.

Function
REQ-015 SHALL implement states IDLE, HOLD and DELAY.
REQ-016 instr_ready SHALL be 1 only in IDLE with flush=0.
REQ-017 Accept (instr_valid & instr_ready) SHALL register fields and enter HOLD; out_valid=1 the next cycle, giving 1-cycle latency.
REQ-018 op=instr[15:13], op1=instr[7:5], op2=instr[4:0]; F=instr[12:8]; n=min(sideset_bits, MAX_SIDESET).
REQ-019 side_set SHALL be the low n bits of F, zero-extended; delay SHALL be F>>n; n=0 gives side_set=0 and delay=F.
REQ-020 In HOLD, fields and out_valid SHALL stay stable until out_ready=1.
REQ-021 On HOLD & out_ready: delay=0 SHALL go to IDLE; otherwise it SHALL go to DELAY with counter=delay.
REQ-022 DELAY SHALL decrement each cycle with busy=1 and out_valid=0; reaching 0 SHALL go to IDLE, giving exactly `delay` stall cycles.
REQ-023 flush=1 SHALL go to IDLE next cycle from any state, with out_valid=0, busy=0 and counter=0; flush beats simultaneous instr_valid, which is not accepted.
REQ-024 Back-to-back: in IDLE with instr_valid held, a new accept SHALL occur in the cycle after HOLD completes (delay=0) or the cycle after the counter reaches 0.

Reset
REQ-025 reset=0 at an edge SHALL force IDLE, counter=0, out_valid=0, busy=0, all field outputs 0 and side_set_en=0, including mid-HOLD or mid-DELAY.
REQ-026 instr_ready SHALL be 0 while reset=0.

Configuration
REQ-027 Macro PIO_SIDESET_OPT_EN SHALL compile in optional side-set.
REQ-028 With PIO_SIDESET_OPT_EN and n>0: side_set_en=F[4]; side_set = low (n-1) bits of F; delay = F[3:0]>>(n-1).
REQ-029 Without PIO_SIDESET_OPT_EN: side_set_en=(n!=0), and REQ-019 applies unchanged.

Structure
REQ-030 A shared package SHALL hold the state encoding, the opcode constants (JMP..SET, 0-7) and the field bit positions.
REQ-031 Field extraction SHALL be a combinational sub-module pio_field_split; the FSM and counter stay in pio_decode_stage.

Verification
REQ-032 Bench SHALL check: no macro, sideset_bits=2, instr=16'hF345, out_ready=1 -> op=7, op1=2, op2=5, side_set=3, delay=4, side_set_en=1; busy for exactly 4 cycles, then instr_ready=1.
REQ-033 Bench SHALL check: PIO_SIDESET_OPT_EN, sideset_bits=3, instr=16'hF345 -> side_set_en=1, side_set=3, delay=0, return to IDLE right after the handshake.
REQ-034 Bench SHALL check: sideset_bits=7, instr F=5'b11111 -> clamped n=5, side_set=31, delay=0.
REQ-035 Bench SHALL check: out_ready=0 for 3 cycles in HOLD -> fields stable and out_valid=1 throughout; handshake on the 4th cycle.
REQ-036 Bench SHALL check: flush in DELAY with counter=3 and instr_valid=1 -> next cycle IDLE, busy=0, instr not accepted; accepted the cycle after.
REQ-037 Bench SHALL check: reset=0 asserted mid-DELAY -> next edge gives all outputs 0 and IDLE; instr_ready=1 after reset=1.

Source files
------------

// File: rtl/pio_decode_stage_pkg.sv
// Shared definitions for the PIO decode stage: FSM states, opcodes, instruction field positions.
// Side-set decoding alternative is selected with PIO_SIDESET_OPT_EN in the field splitter.
package pio_decode_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DELAY = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_JMP       = 3'd0,
        OP_WAIT      = 3'd1,
        OP_IN        = 3'd2,
        OP_OUT       = 3'd3,
        OP_PUSH_PULL = 3'd4,
        OP_MOV       = 3'd5,
        OP_IRQ       = 3'd6,
        OP_SET       = 3'd7
    } opcode_t;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 13;
    localparam int F_HI   = 12;
    localparam int F_LO   = 8;
    localparam int OP1_HI = 7;
    localparam int OP1_LO = 5;
    localparam int OP2_HI = 4;
    localparam int OP2_LO = 0;

    function automatic logic [2:0] clamp_sideset(input logic [2:0] bits, input int max_n);
        if (int'(bits) > max_n)
            return 3'(max_n);
        return bits;
    endfunction

    // Mask of the low n bits of the 5-bit shared field; saturates to all ones for n >= 5.
    function automatic logic [4:0] side_mask(input logic [2:0] n);
        logic [5:0] w_full;
        w_full = (6'd1 << n) - 6'd1;
        return w_full[4:0];
    endfunction

endpackage

// File: rtl/pio_decode_stage_field_split.sv
// Combinational split of a PIO instruction into opcode, operands, side-set and delay.
// PIO_SIDESET_OPT_EN: MSB of the shared field becomes the side-set enable.
module pio_field_split
    import pio_decode_stage_pkg::*;
#(
    parameter int MAX_SIDESET = 5
) (
    input  logic [15:0] i_instr,
    input  logic [2:0]  i_sideset_bits,
    output logic [2:0]  o_op,
    output logic [2:0]  o_op1,
    output logic [4:0]  o_op2,
    output logic [4:0]  o_delay,
    output logic [4:0]  o_side_set,
    output logic        o_side_set_en
);

    logic [4:0] w_f;
    logic [2:0] w_n;
    logic [4:0] w_mask;

    assign w_f   = i_instr[F_HI:F_LO];
    assign w_n   = clamp_sideset(i_sideset_bits, MAX_SIDESET);
    assign o_op  = i_instr[OP_HI:OP_LO];
    assign o_op1 = i_instr[OP1_HI:OP1_LO];
    assign o_op2 = i_instr[OP2_HI:OP2_LO];

`ifdef PIO_SIDESET_OPT_EN
    logic [2:0] w_m;

    // One of the n side-set bits is spent on the enable flag at F[4].
    assign w_m    = w_n - 3'd1;
    assign w_mask = side_mask(w_m);

    always_comb begin
        o_side_set_en = 1'b0;
        o_side_set    = 5'd0;
        o_delay       = w_f;
        if (w_n != 3'd0) begin
            o_side_set_en = w_f[4];
            o_side_set    = {1'b0, w_f[3:0]} & w_mask;
            o_delay       = {1'b0, w_f[3:0] >> w_m};
        end
    end
`else
    assign w_mask        = side_mask(w_n);
    assign o_side_set_en = (w_n != 3'd0);
    assign o_side_set    = w_f & w_mask;
    assign o_delay       = w_f >> w_n;
`endif

endmodule

// File: rtl/pio_decode_stage.sv
// PIO decode stage: accepts one instruction, holds decoded fields until consumed, then stalls for its delay.
// Define PIO_SIDESET_OPT_EN to build the optional side-set (enable bit) decoding.
module pio_decode_stage
    import pio_decode_stage_pkg::*;
#(
    parameter int MAX_SIDESET = 5,
    parameter int DCNT_W      = 5
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  sideset_bits,
    input  logic        flush,
    output logic [2:0]  op,
    output logic [2:0]  op1,
    output logic [4:0]  op2,
    output logic [4:0]  delay,
    output logic [4:0]  side_set,
    output logic        side_set_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    state_t            r_state;
    logic [DCNT_W-1:0] r_cnt;
    logic [2:0]        r_op;
    logic [2:0]        r_op1;
    logic [4:0]        r_op2;
    logic [4:0]        r_delay;
    logic [4:0]        r_side_set;
    logic              r_side_set_en;
    logic              r_out_valid;
    logic              r_busy;

    logic [2:0] w_op;
    logic [2:0] w_op1;
    logic [4:0] w_op2;
    logic [4:0] w_delay;
    logic [4:0] w_side_set;
    logic       w_side_set_en;
    logic       w_accept;

    pio_field_split #(
        .MAX_SIDESET (MAX_SIDESET)
    ) u_split (
        .i_instr        (instr),
        .i_sideset_bits (sideset_bits),
        .o_op           (w_op),
        .o_op1          (w_op1),
        .o_op2          (w_op2),
        .o_delay        (w_delay),
        .o_side_set     (w_side_set),
        .o_side_set_en  (w_side_set_en)
    );

    // Flush must block acceptance in the same cycle, so ready is not registered.
    assign instr_ready = reset & ~flush & (r_state == IDLE);
    assign w_accept    = instr_valid & instr_ready;

    always_ff @(posedge pclk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_op          <= 3'd0;
            r_op1         <= 3'd0;
            r_op2         <= 5'd0;
            r_delay       <= 5'd0;
            r_side_set    <= 5'd0;
            r_side_set_en <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op          <= w_op;
                        r_op1         <= w_op1;
                        r_op2         <= w_op2;
                        r_delay       <= w_delay;
                        r_side_set    <= w_side_set;
                        r_side_set_en <= w_side_set_en;
                        r_out_valid   <= 1'b1;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_delay == 5'd0) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DELAY;
                            r_cnt   <= DCNT_W'(r_delay);
                            r_busy  <= 1'b1;
                        end
                    end
                end
                DELAY: begin
                    // Leaving on the count of 1 yields exactly `delay` busy cycles.
                    if (r_cnt <= DCNT_W'(1)) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - DCNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign op          = r_op;
    assign op1         = r_op1;
    assign op2         = r_op2;
    assign delay       = r_delay;
    assign side_set    = r_side_set;
    assign side_set_en = r_side_set_en;
    assign out_valid   = r_out_valid;
    assign busy        = r_busy;

endmodule

// File: tb/tb_pio_decode_stage.sv
// Scoreboard bench for pio_decode_stage: directed instructions, expected fields queued at accept,
// monitor compares on each output handshake.
module tb_pio_decode_stage;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] op1;
        logic [4:0] op2;
        logic [4:0] dly;
        logic [4:0] ss;
        logic       en;
    } exp_t;

    logic        pclk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr = 16'd0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  sideset_bits = 3'd0;
    logic        flush = 1'b0;
    logic [2:0]  op;
    logic [2:0]  op1;
    logic [4:0]  op2;
    logic [4:0]  delay;
    logic [4:0]  side_set;
    logic        side_set_en;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    pio_decode_stage dut (
        .pclk         (pclk),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .sideset_bits (sideset_bits),
        .flush        (flush),
        .op           (op),
        .op1          (op1),
        .op2          (op2),
        .delay        (delay),
        .side_set     (side_set),
        .side_set_en  (side_set_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #2;
    endtask

    // Monitor: every output handshake must match the oldest queued expectation.
    always @(negedge pclk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got op=%0d with empty scoreboard", op);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("handshake op=%0d op1=%0d op2=%0d delay=%0d side_set=%0d en=%0d",
                         op, op1, op2, delay, side_set, side_set_en);
                chk("op", 32'(op), 32'(e.op));
                chk("op1", 32'(op1), 32'(e.op1));
                chk("op2", 32'(op2), 32'(e.op2));
                chk("delay", 32'(delay), 32'(e.dly));
                chk("side_set", 32'(side_set), 32'(e.ss));
                chk("side_set_en", 32'(side_set_en), 32'(e.en));
            end
        end
    end

    // Presents an instruction, waits (bounded) for ready, queues its expectation, returns after the accept edge.
    task automatic accept(input logic [15:0] ins, input logic [2:0] ssb, input exp_t e);
        int waited;
        instr        = ins;
        sideset_bits = ssb;
        instr_valid  = 1'b1;
        #1;
        waited = 0;
        while (!instr_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!instr_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: instr 0x%0h never accepted", ins);
        end
        exp_q.push_back(e);
        tick();
        instr_valid = 1'b0;
        $display("accepted instr=0x%04h sideset_bits=%0d", ins, ssb);
    endtask

    // Called just after the handshake edge; counts busy cycles until the stage is free again.
    task automatic count_stall(input int exp_cycles);
        int n;
        n = 0;
        while (busy && n < 40) begin
            chk("ov_in_delay", 32'(out_valid), 32'd0);
            n++;
            tick();
        end
        chk("stall_cycles", 32'(n), 32'(exp_cycles));
        chk("ready_after", 32'(instr_ready), 32'd1);
    endtask

    task automatic run_one(input logic [15:0] ins, input logic [2:0] ssb, input exp_t e);
        accept(ins, ssb, e);
        chk("hold_valid", 32'(out_valid), 32'd1);
        tick();
        count_stall(int'(e.dly));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e_a, e_f, e_b, e_c, e_d, e_d2;
`ifdef PIO_SIDESET_OPT_EN
        e_a = '{op: 3'd7, op1: 3'd2, op2: 5'd5, dly: 5'd1, ss: 5'd1,  en: 1'b1};
        e_f = '{op: 3'd7, op1: 3'd2, op2: 5'd5, dly: 5'd0, ss: 5'd3,  en: 1'b1};
        e_b = '{op: 3'd1, op1: 3'd5, op2: 5'd10, dly: 5'd0, ss: 5'd15, en: 1'b1};
`else
        e_a = '{op: 3'd7, op1: 3'd2, op2: 5'd5, dly: 5'd4, ss: 5'd3,  en: 1'b1};
        e_f = '{op: 3'd7, op1: 3'd2, op2: 5'd5, dly: 5'd2, ss: 5'd3,  en: 1'b1};
        e_b = '{op: 3'd1, op1: 3'd5, op2: 5'd10, dly: 5'd0, ss: 5'd31, en: 1'b1};
`endif
        e_c  = '{op: 3'd2, op1: 3'd1, op2: 5'd1, dly: 5'd2, ss: 5'd0, en: 1'b0};
        e_d  = '{op: 3'd6, op1: 3'd3, op2: 5'd7, dly: 5'd5, ss: 5'd0, en: 1'b0};
        e_d2 = '{op: 3'd1, op1: 3'd0, op2: 5'd3, dly: 5'd0, ss: 5'd0, en: 1'b0};

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fields", 32'({op, op1, op2, delay, side_set, side_set_en}), 32'd0);
        chk("rst_ready_low", 32'(instr_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_ready_high", 32'(instr_ready), 32'd1);
        tick();

        // Main decode cases, consumer always ready
        run_one(16'hF345, 3'd2, e_a);
        run_one(16'hF345, 3'd3, e_f);
        run_one(16'h3FAA, 3'd7, e_b);

        // Consumer stalls three cycles in HOLD
        out_ready = 1'b0;
        accept(16'h4221, 3'd0, e_c);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_fields", 32'({op, op1, op2, delay, side_set, side_set_en}), 32'(e_c));
            tick();
        end
        out_ready = 1'b1;
        tick();
        count_stall(2);

        // Flush in DELAY at counter 3 beats a simultaneous instruction
        accept(16'hC567, 3'd0, e_d);
        repeat (3) tick();
        flush       = 1'b1;
        instr       = 16'h2003;
        instr_valid = 1'b1;
        #1;
        chk("flush_ready_low", 32'(instr_ready), 32'd0);
        tick();
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        accept(16'h2003, 3'd0, e_d2);
        chk("post_flush_hold", 32'(out_valid), 32'd1);
        tick();
        chk("post_flush_ready", 32'(instr_ready), 32'd1);

        // Reset asserted mid-DELAY
        accept(16'hC567, 3'd0, e_d);
        repeat (2) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        chk("mid_rst_valid_busy", 32'({out_valid, busy}), 32'd0);
        chk("mid_rst_fields", 32'({op, op1, op2, delay, side_set, side_set_en}), 32'd0);
        chk("mid_rst_ready_low", 32'(instr_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready_high", 32'(instr_ready), 32'd1);

        repeat (3) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
